// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encodings,
// the debug state struct and the byte-strobe merge helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel progress: which of AW / W has been captured, then response.
    typedef enum logic [2:0] {
        WS_INIT    = 3'd0,  // first cycle after reset, all readies low
        WS_IDLE    = 3'd1,  // AWREADY=WREADY=1
        WS_HAVE_AW = 3'd2,  // address captured, waiting for data
        WS_HAVE_W  = 3'd3,  // data captured, waiting for address
        WS_FULL    = 3'd4,  // both captured, commit on next edge
        WS_RESP    = 3'd5   // BVALID held until BREADY
    } wr_state_e;

    typedef enum logic [1:0] {
        RS_INIT = 2'd0,     // first cycle after reset, ARREADY low
        RS_IDLE = 2'd1,     // ARREADY=1
        RS_RESP = 2'd2      // RVALID held until RREADY
    } rd_state_e;

    typedef struct packed {
        wr_state_e wr;
        rd_state_e rd;
    } dbg_t;

    // Replace byte b of old_w with byte b of new_w wherever strb[b] is set.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_w,
                                                 input logic [31:0] new_w,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle. Handshake rule on every channel: a transfer happens
// at a rising edge where both VALID and READY are high; once VALID is raised
// the sender holds it and its payload stable until that edge.
interface axi4_lite_slave_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi4_lite_regfile.sv
// Register array with byte-strobe writes, one-cycle write pulses and a
// combinational read port (reads see the value before a same-edge write).
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [31:0]              wr_data_i,
    input  logic [3:0]               wr_strb_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [31:0]              rd_data_o,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    logic [31:0]         regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    // Merge strobed bytes into the addressed register.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst_i) begin
                regs_q[i] <= '0;
            end else if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
                regs_q[i] <= apply_strobe(regs_q[i], wr_data_i, wr_strb_i);
            end
        end
    end

    // Pulse the written register's bit for exactly one cycle after the commit.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst_i) wr_pulse_q[i] <= 1'b0;
            else       wr_pulse_q[i] <= wr_en_i && (wr_idx_i == IDX_W'(i));
        end
    end

    // Read mux; a compare loop keeps out-of-range indices returning zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_data_o = regs_q[i];
        end
    end

    // Flatten the array onto the user-facing bus.
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite responder exposing NUM_REGS 32-bit registers. Independent write
// and read FSMs, one outstanding transaction per direction.
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    axi4_lite_slave_if.slave       s,
    output logic [32*NUM_REGS-1:0] oREGS,
    output logic [NUM_REGS-1:0]    oWR_PULSE,
    output dbg_t                   oDBG
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic [31:0] aw_addr_q, w_data_q, rdata_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rd_data;
    logic        unused_prot;

    function automatic logic addr_hit(input logic [31:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < 32'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign aw_hs  = s.AWVALID & aw_ready;
    assign w_hs   = s.WVALID  & w_ready;
    assign b_hs   = b_valid   & s.BREADY;
    assign ar_hs  = s.ARVALID & ar_ready;
    assign r_hs   = r_valid   & s.RREADY;
    assign commit = (wr_state_q == WS_FULL);

    // FSM state registers; reset parks both FSMs with all readies low.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_state_q <= WS_INIT;
            rd_state_q <= RS_INIT;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    // Write FSM next state: capture AW and W in any order, commit, respond.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WS_INIT:    wr_state_d = WS_IDLE;
            WS_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WS_FULL;
                else if (aw_hs)    wr_state_d = WS_HAVE_AW;
                else if (w_hs)     wr_state_d = WS_HAVE_W;
            end
            WS_HAVE_AW: if (w_hs)  wr_state_d = WS_FULL;
            WS_HAVE_W:  if (aw_hs) wr_state_d = WS_FULL;
            WS_FULL:    wr_state_d = WS_RESP;
            WS_RESP:    if (b_hs)  wr_state_d = WS_IDLE;
            default:    wr_state_d = WS_INIT;
        endcase
    end

    // Read FSM next state: accept address, hold response until taken.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RS_INIT: rd_state_d = RS_IDLE;
            RS_IDLE: if (ar_hs) rd_state_d = RS_RESP;
            RS_RESP: if (r_hs)  rd_state_d = RS_IDLE;
            default: rd_state_d = RS_INIT;
        endcase
    end

    // Channel handshake outputs decoded straight from the state registers.
    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (wr_state_q)
            WS_IDLE:    begin aw_ready = 1'b1; w_ready = 1'b1; end
            WS_HAVE_AW: w_ready  = 1'b1;
            WS_HAVE_W:  aw_ready = 1'b1;
            WS_RESP:    b_valid  = 1'b1;
            default:    ;
        endcase
        case (rd_state_q)
            RS_IDLE: ar_ready = 1'b1;
            RS_RESP: r_valid  = 1'b1;
            default: ;
        endcase
    end

    // Write payload capture and response code at commit.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) aw_addr_q <= s.AWADDR;
            if (w_hs) begin
                w_data_q <= s.WDATA;
                w_strb_q <= s.WSTRB;
            end
            if (commit) bresp_q <= addr_hit(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read data sampled at the AR handshake and held until the R handshake.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= addr_hit(s.ARADDR) ? rd_data : 32'h0;
            rresp_q <= addr_hit(s.ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axi4_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .wr_en_i    (commit && addr_hit(aw_addr_q)),
        .wr_idx_i   (addr_idx(aw_addr_q)),
        .wr_data_i  (w_data_q),
        .wr_strb_i  (w_strb_q),
        .rd_idx_i   (addr_idx(s.ARADDR)),
        .rd_data_o  (rd_data),
        .regs_o     (oREGS),
        .wr_pulse_o (oWR_PULSE)
    );

    assign s.AWREADY = aw_ready;
    assign s.WREADY  = w_ready;
    assign s.BVALID  = b_valid;
    assign s.BRESP   = bresp_q;
    assign s.ARREADY = ar_ready;
    assign s.RVALID  = r_valid;
    assign s.RDATA   = rdata_q;
    assign s.RRESP   = rresp_q;

    assign oDBG.wr = wr_state_q;
    assign oDBG.rd = rd_state_q;

    assign unused_prot = ^{s.AWPROT, s.ARPROT};

endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
AXI4-Lite subordinate (responder) terminating the write and read channels driven by the team's AXI4-Lite master. It exposes NUM_REGS 32-bit read/write registers with byte-strobe writes and OKAY/SLVERR responses. Register contents and per-register write pulses go to user logic. One outstanding write and one outstanding read at a time; the read and write paths run independently.

Parameters:
NUM_REGS, 8, number of 32-bit registers (1..64)
BASE_ADDR, 32'h0000_0000, byte address of register 0; 4-byte aligned

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous reset, active-high
s_AWVALID  in  1  write address valid
s_AWREADY  out  1  write address ready (registered)
s_AWADDR  in  32  write byte address
s_AWPROT  in  3  ignored
s_WVALID  in  1  write data valid
s_WREADY  out  1  write data ready (registered)
s_WDATA  in  32  write data
s_WSTRB  in  4  byte enables
s_BVALID  out  1  write response valid
s_BREADY  in  1  write response ready
s_BRESP  out  2  write response
s_ARVALID  in  1  read address valid
s_ARREADY  out  1  read address ready (registered)
s_ARADDR  in  32  read byte address
s_ARPROT  in  3  ignored
s_RVALID  out  1  read data valid
s_RREADY  in  1  read data ready
s_RDATA  out  32  read data
s_RRESP  out  2  read response
oREGS  out  32*NUM_REGS  flat register contents; reg i at [32*i+31:32*i]
oWR_PULSE  out  NUM_REGS  one-cycle strobe; bit i high the cycle after reg i is written

Behaviour:
- iRST high at posedge: all registers, oREGS, oWR_PULSE, s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID, s_BRESP, s_RRESP, s_RDATA become 0; aw/w capture flags cleared. The first edge after reset release sets s_AWREADY, s_WREADY and s_ARREADY to 1. Reset mid-transaction discards it; no response is issued.
- Decode: hit when addr >= BASE_ADDR and idx = (addr-BASE_ADDR)>>2 < NUM_REGS. addr[1:0] is ignored. A miss produces RESP 2'b10 (SLVERR); a hit produces 2'b00 (OKAY).
- Write path:
  - AW handshake (AWVALID&AWREADY) at an edge latches the address, sets aw_full and clears AWREADY.
  - W handshake latches data and strobe, sets w_full and clears WREADY.
  - AW and W may arrive in either order or in the same cycle.
  - At the first edge where aw_full&w_full&!BVALID:
    - On a hit, update bytes b with WSTRB[b]=1 and set oWR_PULSE[idx] for one cycle.
    - Set BVALID, drive BRESP, clear both flags.
  - WSTRB=0 on a hit: OKAY, no data change, pulse still fires.
  - A miss leaves register state unchanged and fires no pulse.
  - B handshake at an edge clears BVALID and sets AWREADY=WREADY=1.
  - BVALID and BRESP hold stable until BREADY.
  - Minimum latency, AW+W in the same cycle: edge0 accept, edge1 BVALID; the next AW can be accepted at the edge after the B handshake.
- Read path:
  - AR handshake at an edge sets ARREADY=0 and RVALID=1, and loads RDATA=reg[idx] (0 on a miss) and RRESP.
  - RDATA and RRESP hold until the R handshake. That edge clears RVALID and sets ARREADY=1.
  - Latency: RVALID one cycle after the AR handshake.
- Simultaneous read and write commit to the same register at one edge: the read returns the pre-write value.
- oREGS reflects a write from the edge of the commit onward.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
  - A function applying a 4-bit strobe to 32-bit old/new words. The same function serves both master and slave benches.
- One natural sub-module, axi4_lite_regfile: register array, strobe merge, write pulses, async read port. The protocol handshake FSMs stay in the top module.

Test Plan:
- Reset, then AW=0x4, W=0xDEADBEEF, STRB=4'hF in the same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=00, oREGS[63:32]=0xDEADBEEF, oWR_PULSE=8'h02 for 1 cycle.
- W (0x11223344, STRB=4'b0101) 3 cycles before AW=0x8 onto reg2=0xAABBCCDD -> reg2=0xAA22CC44; AWREADY/WREADY stay low until the B handshake.
- Read 0x4 with RREADY held low 4 cycles -> RVALID=1 and RDATA=0xDEADBEEF stable throughout; ARREADY=0 until the R handshake.
- Write 0x20 and read 0x40 (NUM_REGS=8) -> BRESP=10 with no register or pulse change; RRESP=10 with RDATA=0.
- Same-edge write reg0 0x5 and read reg0 (old 0x0) -> RDATA=0x0; a subsequent read gives 0x5.
- iRST asserted while BVALID=1 -> all outputs 0 next edge; no B issued; READY signals return 1 one edge after release.
